multiplier_sequential: RTL
==========================

# multiplier_sequential

Parametrised shift-and-add multiplier computing p = m × q, one partial-product row per clock. It supersedes the fixed-size combinational array multipliers as the general-purpose multiply unit. Operands are accepted with a start/ready handshake, and the product is returned with a valid/ready handshake, so the unit can sit between registered datapath stages that may stall.

## Interface
- M_WIDTH, 8, multiplicand width (≥2)
- Q_WIDTH, 8, multiplier width (≥2); also the number of compute cycles
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  operand-valid request; sampled only while start_ready=1
- m  input  M_WIDTH  multiplicand
- q  input  Q_WIDTH  multiplier
- start_ready  output  1  high in IDLE only
- busy  output  1  high in RUN
- result_valid  output  1  high in DONE
- result_ready  input  1  consumer accepts the product
- p  output  M_WIDTH+Q_WIDTH  product, valid while result_valid=1

## Operation
- State machine with states IDLE, RUN, DONE:
  - IDLE: start=1 → latch m_reg, q_reg; acc←0; count←0; go to RUN.
  - RUN: each cycle, if q_reg[count]=1, acc←acc + (m_ext << count); count←count+1. When count reaches Q_WIDTH-1, go to DONE after that final add.
  - DONE: hold acc. result_ready=1 → go to IDLE.
- m_ext is m_reg zero-extended to M_WIDTH+Q_WIDTH; arithmetic is modulo 2^(M_WIDTH+Q_WIDTH). The unsigned product always fits.
- p is driven directly from acc. Its value in RUN is an intermediate sum and is not defined to consumers.
- start in RUN or DONE is ignored and does not queue.
- start in DONE while result_ready=1: the handshake completes and the state returns to IDLE. start is not accepted that cycle because start_ready=0.
- Operand changes after acceptance have no effect.
- q=0 or m=0 still takes the full Q_WIDTH cycles. There is no early exit.

## Timing
- Reset values: state=IDLE, acc=0, count=0, p=0, start_ready=1, busy=0, result_valid=0.
- Reset takes priority over every other event, including mid-RUN and in DONE. The in-flight result is discarded and no result_valid is produced.
- Start accepted on edge E0. RUN occupies edges E1..EQ_WIDTH. result_valid rises after edge EQ_WIDTH. Latency is Q_WIDTH+1 edges from acceptance.
- result_valid stays high with p stable for as long as result_ready=0.
- Minimum issue interval is Q_WIDTH+2 cycles: start, Q_WIDTH RUN cycles, one DONE cycle with immediate ready, then IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- MULTIPLIER_SIGNED_EN defined: m and q are two's complement.
  - m_ext is sign-extended.
  - The row for q_reg[Q_WIDTH-1] is subtracted instead of added: acc←acc − (m_ext << (Q_WIDTH-1)).
  - p is the signed product in M_WIDTH+Q_WIDTH bits.
- Undefined: unsigned behaviour as above.
- Latency and handshake are identical in both builds.

## Structure
- Shared package multiplier_pkg holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2); 2'd3 is illegal and recovers to IDLE
  - the count width function clog2(Q_WIDTH).
- One sub-module, multiplier_pp_row (combinational), takes m_ext, the q bit, the shift amount and the subtract flag. It returns the signed/unsigned row addend, so the adder stays in the parent.

## Test plan
- Unsigned default build, 8×8:
  - m=13, q=11, start pulse, result_ready=1 → result_valid rises exactly 9 edges after acceptance; p=143; single valid cycle.
  - m=255, q=255 → p=65025.
  - m=0, q=200 → p=0 after the full 9-edge latency.
- Backpressure: hold result_ready=0 for 5 cycles after valid → p and result_valid stable throughout. Pulse start during DONE → ignored. Then release → back-to-back second operation with m=3, q=7 gives p=21.
- Reset mid-RUN, 4 cycles after start → next cycle all outputs are at reset values and no result_valid follows. A fresh operation m=2, q=5 gives p=10.
- Parameter sweep M_WIDTH=2, Q_WIDTH=3: exhaustive 32 operand pairs vs a reference model. Latency is 4 edges.
- MULTIPLIER_SIGNED_EN, 8×8:
  - m=−3 (8'hFD), q=5 → p=16'hFFF1.
  - m=−128, q=−128 → p=16'h4000.
  - m=127, q=−1 → p=16'hFF81.

Source files
------------

// File: rtl/multiplier_pkg.sv
// multiplier_pkg: FSM state encoding and the count-width helper shared by the sequential multiplier.
package multiplier_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/multiplier_pp_row.sv
// multiplier_pp_row: one shifted partial-product row, negated when it carries the signed MSB weight.
module multiplier_pp_row #(
  parameter int W  = 16,
  parameter int SW = 3
) (
  input  logic [W-1:0]  m_ext_i,
  input  logic          q_bit_i,
  input  logic [SW-1:0] shamt_i,
  input  logic          sub_i,
  output logic [W-1:0]  row_o
);
  logic [W-1:0] sh;
  assign sh    = m_ext_i << shamt_i;
  assign row_o = !q_bit_i ? '0 : sub_i ? -sh : sh;
endmodule

// File: rtl/multiplier_sequential.sv
// multiplier_sequential: shift-and-add multiplier, one row per clock, start/ready in and valid/ready out.
// Define MULTIPLIER_SIGNED_EN for two's-complement operands; default build is unsigned.
module multiplier_sequential
  import multiplier_pkg::*;
#(
  parameter int M_WIDTH = 8,
  parameter int Q_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [M_WIDTH-1:0]         m,
  input  logic [Q_WIDTH-1:0]         q,
  output logic                       start_ready,
  output logic                       busy,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [M_WIDTH+Q_WIDTH-1:0] p
);
  localparam int W  = M_WIDTH + Q_WIDTH;
  localparam int CW = clog2(Q_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(Q_WIDTH - 1);
  state_e state_q, state_d;
  logic [M_WIDTH-1:0] m_q, m_d;
  logic [Q_WIDTH-1:0] q_q, q_d;
  logic [W-1:0] acc_q, acc_d, m_ext, row;
  logic [CW-1:0] count_q, count_d;
  logic last, sub;
  assign last = count_q == LAST;
`ifdef MULTIPLIER_SIGNED_EN
  assign m_ext = {{Q_WIDTH{m_q[M_WIDTH-1]}}, m_q};
  assign sub   = last;
`else
  assign m_ext = {{Q_WIDTH{1'b0}}, m_q};
  assign sub   = 1'b0;
`endif
  multiplier_pp_row #(.W(W), .SW(CW)) u_row (
    .m_ext_i (m_ext),
    .q_bit_i (q_q[count_q]),
    .shamt_i (count_q),
    .sub_i   (sub),
    .row_o   (row)
  );
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        m_d     = m;
        q_d     = q;
        acc_d   = '0;
        count_d = '0;
      end
      RUN: begin
        acc_d   = acc_q + row;
        count_d = last ? '0 : count_q + 1'b1;
        state_d = last ? DONE : RUN;
      end
      DONE: state_d = result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end
  assign start_ready  = state_q == IDLE;
  assign busy         = state_q == RUN;
  assign result_valid = state_q == DONE;
  assign p            = acc_q;
endmodule
